wbcav_alarm_ctrl: RTL and testbench
===================================

Name: wbcav_alarm_ctrl

Overview:
Alarm sequencing controller that sits downstream of the WBCAV detector. It turns the detector's raw level alarm into a confirmed, latched alarm.
- It samples the raw alarm on a 1 ms tick generated from the system clock.
- It requires a run of consecutive asserted samples before raising the alarm.
- It holds the alarm until the operator accepts it, then enforces a hold-off before re-arming.
- It counts confirmed events for the status/reporting logic.

Parameters:
CLK_DIV, 100000, system clock cycles per sample tick (1 ms at 100 MHz); minimum 2
CONFIRM_MS, 50, consecutive asserted ticks required to confirm an alarm; minimum 1
HOLDOFF_MS, 5000, ticks spent in hold-off after accept before re-arming; minimum 1
CNT_W, 8, width of confirmed-event counter

Ports:
i_clk  input  1  system clock
i_rst  input  1  reset, asynchronous, active-high
i_alarm_raw  input  1  raw detector alarm level, synchronous to i_clk
i_accept  input  1  operator acknowledge, level, synchronous to i_clk
i_inhibit  input  1  maintenance inhibit; blocks new alarm confirmation
o_tick  output  1  one-cycle strobe per sample tick
o_alarm  output  1  latched confirmed alarm
o_alarm_pulse  output  1  one-cycle strobe on entry to ALARM
o_state  output  2  current FSM state encoding
o_event_cnt  output  CNT_W  confirmed alarm count, saturating

Behaviour:
- Reset (async assert, i_rst high):
  - tick counter = 0, state = ARMED, confirm count = 0, hold-off count = 0.
  - All outputs 0, o_state = 0.
  - Outputs drop immediately, with no clock edge needed.
- Reset deassertion: operation resumes on the next i_clk edge.
- Tick generator:
  - Counter runs 0..CLK_DIV-1 and wraps to 0.
  - o_tick is registered; it is high for the single cycle in which the counter equals CLK_DIV-1.
  - First o_tick after reset is in cycle CLK_DIV.
- Sampling: i_alarm_raw and i_inhibit are evaluated only in cycles where o_tick = 1. i_accept is evaluated every cycle.
- State encoding: ARMED = 0, CONFIRM = 1, ALARM = 2, HOLDOFF = 3.
- ARMED:
  - On tick with raw = 1 and inhibit = 0: confirm count := 1.
  - If CONFIRM_MS = 1, go directly to ALARM; otherwise go to CONFIRM.
- CONFIRM, on each tick:
  - If raw = 0 or inhibit = 1: go to ARMED, confirm count := 0.
  - Otherwise confirm count += 1. When it reaches CONFIRM_MS, go to ALARM.
  - Net effect: ALARM is entered on the CONFIRM_MS-th consecutive qualifying tick.
- Entry to ALARM (the edge at which state becomes ALARM):
  - o_alarm_pulse = 1 for exactly that one cycle.
  - o_event_cnt += 1, saturating at 2^CNT_W-1.
- ALARM:
  - o_alarm = 1.
  - raw and inhibit are ignored; the alarm stays latched.
  - i_accept = 1 in any cycle → HOLDOFF, hold-off count := 0.
  - Accept asserted during the transition cycle into ALARM is not acted on; it is sampled from the first ALARM cycle onward.
  - Accept held high continuously therefore gives exactly one ALARM cycle.
- HOLDOFF:
  - o_alarm = 0.
  - Each tick increments hold-off count. The tick on which it reaches HOLDOFF_MS moves the FSM to ARMED.
  - raw, inhibit and accept are ignored.
  - raw still high on return to ARMED restarts confirmation from count 1 at the next tick.
- Output timing:
  - o_alarm and o_state are registered and change in the same cycle as the state register.
  - Latency from the confirming tick to o_alarm = 1 clock.
- Simultaneous events: a tick coincident with i_accept in ALARM gives accept priority, so the FSM goes to HOLDOFF.
- Counter widths: confirm and hold-off counters are sized by $clog2(param+1), with no wrap reachable. The tick counter is sized by $clog2(CLK_DIV).

Decomposition:
- Shared package wbcav_pkg holds:
  - state encoding localparams: ARMED, CONFIRM, ALARM, HOLDOFF;
  - default tick divisor: 100000.
- One sub-module, wbcav_tick_gen (parameter CLK_DIV; ports i_clk, i_rst, o_tick). It replaces a derived-clock approach: the controller and all detector logic stay on i_clk and use o_tick as an enable.

Test Plan:
Bench parameters: CLK_DIV=4, CONFIRM_MS=3, HOLDOFF_MS=5, CNT_W=2.
1. Reset release, all inputs 0 → o_tick high in cycles 4, 8, 12, …; o_state = 0; o_alarm = 0; o_event_cnt = 0 throughout.
2. raw = 1 for 3 consecutive ticks → o_state goes 1, then 2 on the 3rd tick edge; o_alarm = 1 and o_alarm_pulse = 1 for one cycle, 1 clock after that tick; o_event_cnt = 1.
3. raw high for 2 ticks, then low at the 3rd tick → o_state returns to 0; o_alarm never asserts; o_event_cnt unchanged. Repeat with i_inhibit = 1 at the 2nd tick → same abort.
4. In ALARM: pulse i_accept for 1 cycle → o_alarm = 0 next cycle, o_state = 3. Hold raw = 1 throughout: o_state = 0 after 5 ticks, then o_alarm re-asserts after 3 further ticks; o_event_cnt = 2. i_inhibit = 1 while in ALARM → no change to o_alarm.
5. Drive 4 full confirm/accept/hold-off cycles → o_event_cnt reads 1, 2, 3, 3 (saturated).
6. Assert i_rst asynchronously mid-ALARM, between clock edges → o_alarm, o_state and o_event_cnt read 0 before the next i_clk edge; after release, next o_tick is in cycle 4.

Source files
------------

// File: rtl/wbcav_pkg.sv
// Shared definitions for the WBCAV alarm sequencing path: FSM state encoding
// and the default sample-tick divisor.
package wbcav_pkg;

  localparam logic [1:0] ARMED   = 2'd0;
  localparam logic [1:0] CONFIRM = 2'd1;
  localparam logic [1:0] ALARM   = 2'd2;
  localparam logic [1:0] HOLDOFF = 2'd3;

  localparam int DEFAULT_CLK_DIV = 100000;

  typedef enum logic [1:0] {
    S_ARMED   = ARMED,
    S_CONFIRM = CONFIRM,
    S_ALARM   = ALARM,
    S_HOLDOFF = HOLDOFF
  } state_e;

endpackage

// File: rtl/wbcav_tick_gen.sv
// Sample-tick strobe generator: one-cycle enable every CLK_DIV cycles of i_clk,
// used in place of a derived clock so all downstream logic stays on i_clk.
module wbcav_tick_gen
  import wbcav_pkg::*;
#(
  parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
  input  logic i_clk,
  input  logic i_rst,
  output logic o_tick
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;

  // The strobe is decoded from the next count so it lines up with cnt_q == LAST.
  always_comb begin
    cnt_d  = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    tick_d = (cnt_d == LAST);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign o_tick = tick_q;

endmodule

// File: rtl/wbcav_alarm_ctrl.sv
// Alarm sequencing controller: confirms the raw detector alarm over consecutive
// sample ticks, latches it until accepted, then holds off before re-arming.
module wbcav_alarm_ctrl
  import wbcav_pkg::*;
#(
  parameter int CLK_DIV    = DEFAULT_CLK_DIV,
  parameter int CONFIRM_MS = 50,
  parameter int HOLDOFF_MS = 5000,
  parameter int CNT_W      = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_alarm_raw,
  input  logic             i_accept,
  input  logic             i_inhibit,
  output logic             o_tick,
  output logic             o_alarm,
  output logic             o_alarm_pulse,
  output logic [1:0]       o_state,
  output logic [CNT_W-1:0] o_event_cnt
);

  localparam int CONF_W = $clog2(CONFIRM_MS + 1);
  localparam int HOLD_W = $clog2(HOLDOFF_MS + 1);
  localparam logic [CONF_W-1:0] CONF_LAST = CONF_W'(CONFIRM_MS);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLDOFF_MS);
  localparam logic [CNT_W-1:0]  EVT_MAX   = '1;

  logic tick;

  state_e             state_q, state_d;
  logic [CONF_W-1:0]  conf_q, conf_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [CNT_W-1:0]   evt_q, evt_d;
  logic               alarm_q, alarm_d;
  logic               pulse_q, pulse_d;
  logic               enter_alarm;

  wbcav_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick_gen (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .o_tick (tick)
  );

  always_comb begin
    state_d = state_q;
    conf_d  = conf_q;
    hold_d  = hold_q;
    evt_d   = evt_q;

    case (state_q)
      S_ARMED: begin
        if (tick && i_alarm_raw && !i_inhibit) begin
          if (CONFIRM_MS == 1) begin
            state_d = S_ALARM;
            conf_d  = '0;
          end else begin
            state_d = S_CONFIRM;
            conf_d  = CONF_W'(1);
          end
        end
      end
      S_CONFIRM: begin
        if (tick) begin
          if (!i_alarm_raw || i_inhibit) begin
            state_d = S_ARMED;
            conf_d  = '0;
          end else if (conf_q + CONF_W'(1) == CONF_LAST) begin
            state_d = S_ALARM;
            conf_d  = '0;
          end else begin
            conf_d = conf_q + CONF_W'(1);
          end
        end
      end
      // Accept is checked every cycle, so it wins over a coincident tick.
      S_ALARM: begin
        if (i_accept) begin
          state_d = S_HOLDOFF;
          hold_d  = '0;
        end
      end
      S_HOLDOFF: begin
        if (tick) begin
          if (hold_q + HOLD_W'(1) == HOLD_LAST) begin
            state_d = S_ARMED;
            hold_d  = '0;
          end else begin
            hold_d = hold_q + HOLD_W'(1);
          end
        end
      end
      default: state_d = S_ARMED;
    endcase

    enter_alarm = (state_d == S_ALARM) && (state_q != S_ALARM);
    pulse_d     = enter_alarm;
    alarm_d     = (state_d == S_ALARM);
    if (enter_alarm && (evt_q != EVT_MAX)) begin
      evt_d = evt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_ARMED;
      conf_q  <= '0;
      hold_q  <= '0;
      evt_q   <= '0;
      alarm_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      conf_q  <= conf_d;
      hold_q  <= hold_d;
      evt_q   <= evt_d;
      alarm_q <= alarm_d;
      pulse_q <= pulse_d;
    end
  end

  assign o_tick        = tick;
  assign o_alarm       = alarm_q;
  assign o_alarm_pulse = pulse_q;
  assign o_state       = state_q;
  assign o_event_cnt   = evt_q;

endmodule

// File: tb/tb_wbcav_alarm_ctrl.sv
// Directed self-checking bench for wbcav_alarm_ctrl with a 4-cycle tick,
// 3-tick confirmation, 5-tick hold-off and a 2-bit event counter.
module tb_wbcav_alarm_ctrl;

  logic       clk;
  logic       rst;
  logic       raw;
  logic       accept;
  logic       inhibit;
  logic       tick;
  logic       alarm;
  logic       pulse;
  logic [1:0] state;
  logic [1:0] evt;

  int checks;
  int errors;

  wbcav_alarm_ctrl #(
    .CLK_DIV    (4),
    .CONFIRM_MS (3),
    .HOLDOFF_MS (5),
    .CNT_W      (2)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_alarm_raw   (raw),
    .i_accept      (accept),
    .i_inhibit     (inhibit),
    .o_tick        (tick),
    .o_alarm       (alarm),
    .o_alarm_pulse (pulse),
    .o_state       (state),
    .o_event_cnt   (evt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and sample 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Move to the next cycle in which o_tick is high (bounded).
  task automatic wait_tick(input string tag);
    int n;
    n = 0;
    while (tick !== 1'b1 && n < 8) begin
      step();
      n++;
    end
    checks++;
    if (tick !== 1'b1) begin
      errors++;
      $display("FAIL %s_tick_timeout: o_tick=%b after %0d cycles, required 1", tag, tick, n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; raw = 1'b0; accept = 1'b0; inhibit = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({tick, alarm, pulse, state, evt} !== 7'd0) begin
      errors++;
      $display("FAIL reset_outputs: got tick=%b alarm=%b pulse=%b state=%0d evt=%0d, required all 0",
               tick, alarm, pulse, state, evt);
    end
    rst = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      step();
      checks++;
      if (tick !== ((k % 4) == 3)) begin
        errors++;
        $display("FAIL idle_tick_cycle%0d: o_tick=%b, required %b", k + 1, tick, (k % 4) == 3);
      end
      checks++;
      if ({alarm, state, evt} !== 5'd0) begin
        errors++;
        $display("FAIL idle_quiet_cycle%0d: alarm=%b state=%0d evt=%0d, required 0", k + 1, alarm, state, evt);
      end
    end
    $display("test_reset done: %0d checks, %0d errors", checks, errors);
  endtask

  task automatic test_confirm();
    wait_tick("confirm1");
    raw = 1'b1;
    step();
    checks++;
    if (state !== 2'd1) begin
      errors++;
      $display("FAIL confirm_state_t1: state=%0d, required 1", state);
    end
    wait_tick("confirm2");
    step();
    checks++;
    if (state !== 2'd1 || alarm !== 1'b0) begin
      errors++;
      $display("FAIL confirm_state_t2: state=%0d alarm=%b, required 1/0", state, alarm);
    end
    wait_tick("confirm3");
    step();
    checks++;
    if (state !== 2'd2 || alarm !== 1'b1 || pulse !== 1'b1 || evt !== 2'd1) begin
      errors++;
      $display("FAIL confirm_enter_alarm: state=%0d alarm=%b pulse=%b evt=%0d, required 2/1/1/1",
               state, alarm, pulse, evt);
    end
    step();
    checks++;
    if (pulse !== 1'b0 || alarm !== 1'b1) begin
      errors++;
      $display("FAIL confirm_pulse_width: pulse=%b alarm=%b, required 0/1", pulse, alarm);
    end
    $display("test_confirm done: %0d checks, %0d errors", checks, errors);
  endtask

  task automatic test_alarm_accept();
    inhibit = 1'b1;
    raw = 1'b0;
    for (int t = 0; t < 2; t++) begin
      wait_tick("inhibit_alarm");
      step();
      checks++;
      if (alarm !== 1'b1 || state !== 2'd2) begin
        errors++;
        $display("FAIL alarm_latched_t%0d: alarm=%b state=%0d, required 1/2", t, alarm, state);
      end
    end
    inhibit = 1'b0;
    raw = 1'b1;
    accept = 1'b1;
    step();
    accept = 1'b0;
    checks++;
    if (alarm !== 1'b0 || state !== 2'd3) begin
      errors++;
      $display("FAIL accept_to_holdoff: alarm=%b state=%0d, required 0/3", alarm, state);
    end
    for (int t = 1; t <= 5; t++) begin
      wait_tick("holdoff");
      step();
      checks++;
      if (state !== ((t < 5) ? 2'd3 : 2'd0)) begin
        errors++;
        $display("FAIL holdoff_t%0d: state=%0d, required %0d", t, state, (t < 5) ? 3 : 0);
      end
    end
    for (int t = 1; t <= 3; t++) begin
      wait_tick("rearm");
      step();
      checks++;
      if (alarm !== (t == 3) || state !== ((t < 3) ? 2'd1 : 2'd2)) begin
        errors++;
        $display("FAIL rearm_t%0d: alarm=%b state=%0d, required %b/%0d", t, alarm, state, t == 3, (t < 3) ? 1 : 2);
      end
    end
    checks++;
    if (evt !== 2'd2) begin
      errors++;
      $display("FAIL rearm_evt: evt=%0d, required 2", evt);
    end
    $display("test_alarm_accept done: %0d checks, %0d errors", checks, errors);
  endtask

  task automatic test_abort();
    // Leave ALARM and sit out the hold-off with raw low.
    raw = 1'b0;
    accept = 1'b1;
    step();
    accept = 1'b0;
    for (int t = 1; t <= 5; t++) begin
      wait_tick("abort_holdoff");
      step();
    end
    checks++;
    if (state !== 2'd0) begin
      errors++;
      $display("FAIL abort_armed: state=%0d, required 0", state);
    end
    for (int pass = 0; pass < 2; pass++) begin
      wait_tick("abort_a");
      raw = 1'b1;
      step();
      if (pass == 1) inhibit = 1'b1;
      wait_tick("abort_b");
      step();
      if (pass == 0) begin
        checks++;
        if (state !== 2'd1) begin
          errors++;
          $display("FAIL abort_raw_t2: state=%0d, required 1", state);
        end
        wait_tick("abort_c");
        raw = 1'b0;
        step();
      end
      checks++;
      if (state !== 2'd0 || alarm !== 1'b0 || evt !== 2'd2) begin
        errors++;
        $display("FAIL abort_pass%0d: state=%0d alarm=%b evt=%0d, required 0/0/2", pass, state, alarm, evt);
      end
      raw = 1'b0;
      inhibit = 1'b0;
    end
    $display("test_abort done: %0d checks, %0d errors", checks, errors);
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_evt;
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int n = 1; n <= 4; n++) begin
      exp_evt = (n < 3) ? 2'(n) : 2'd3;
      wait_tick("b2b1");
      raw = 1'b1;
      step();
      wait_tick("b2b2");
      step();
      wait_tick("b2b3");
      accept = 1'b1;
      step();
      checks++;
      if (state !== 2'd2 || pulse !== 1'b1 || evt !== exp_evt) begin
        errors++;
        $display("FAIL b2b_enter_n%0d: state=%0d pulse=%b evt=%0d, required 2/1/%0d", n, state, pulse, evt, exp_evt);
      end
      step();
      accept = 1'b0;
      raw = 1'b0;
      checks++;
      if (state !== 2'd3 || alarm !== 1'b0) begin
        errors++;
        $display("FAIL b2b_one_alarm_cycle_n%0d: state=%0d alarm=%b, required 3/0", n, state, alarm);
      end
      for (int t = 1; t <= 5; t++) begin
        wait_tick("b2b_hold");
        step();
      end
      checks++;
      if (state !== 2'd0) begin
        errors++;
        $display("FAIL b2b_rearm_n%0d: state=%0d, required 0", n, state);
      end
      $display("b2b cycle %0d: evt=%0d", n, evt);
    end
    $display("test_back_to_back done: %0d checks, %0d errors", checks, errors);
  endtask

  task automatic test_async_reset();
    raw = 1'b1;
    for (int t = 0; t < 3; t++) begin
      wait_tick("ar");
      step();
    end
    raw = 1'b0;
    checks++;
    if (alarm !== 1'b1) begin
      errors++;
      $display("FAIL ar_pre_alarm: alarm=%b, required 1", alarm);
    end
    step();
    #2 rst = 1'b1;
    #1;
    checks++;
    if (alarm !== 1'b0 || state !== 2'd0 || evt !== 2'd0 || tick !== 1'b0) begin
      errors++;
      $display("FAIL ar_immediate: alarm=%b state=%0d evt=%0d tick=%b, required 0", alarm, state, evt, tick);
    end
    #2 rst = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      step();
      checks++;
      if (tick !== (k == 3)) begin
        errors++;
        $display("FAIL ar_tick_cycle%0d: o_tick=%b, required %b", k + 1, tick, k == 3);
      end
    end
    $display("test_async_reset done: %0d checks, %0d errors", checks, errors);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_confirm();
    test_alarm_accept();
    test_abort();
    test_back_to_back();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
